// File: rtl/inst_fetch_linebuf_if.sv
// rtl/inst_fetch_linebuf_if.sv - core fetch port and memory bus bundle for the line buffer
interface inst_fetch_linebuf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_ce_i;
  logic [ADDR_W-1:0] rom_addr_i;
  logic [DATA_W-1:0] rom_data_o;
  logic              stallreq_o;
  logic              flush_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output rom_ce_i, rom_addr_i, flush_i, mem_ack_i, mem_rdata_i,
    input  rom_data_o, stallreq_o, mem_req_o, mem_addr_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, flush_i, mem_ack_i, mem_rdata_i,
    output rom_data_o, stallreq_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/inst_fetch_linebuf.sv
// rtl/inst_fetch_linebuf.sv - one-line instruction buffer with word-serial burst refill
// Optional IFB_PERF_CNT_EN adds saturating hit/miss counters.
module inst_fetch_linebuf #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_linebuf_if.slave bus
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic               valid_q;
  logic               flush_pend_q;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   fill_idx_q;
  logic [DATA_W-1:0]  line_q [LINE_WORDS];

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               hit;
  logic               miss;
  logic               fill_last;
  logic               unused_addr_lsbs;

  assign req_tag          = bus.rom_addr_i[ADDR_W-1:2+IDX_W];
  assign req_idx          = bus.rom_addr_i[2+IDX_W-1:2];
  assign unused_addr_lsbs = ^bus.rom_addr_i[1:0];
  assign hit              = bus.rom_ce_i & valid_q & (req_tag == tag_q) & (state_q == IDLE);
  assign fill_last        = (state_q == FILL) & bus.mem_ack_i & (fill_idx_q == LAST_IDX);

  // Outputs are gated by rst so a reset asserted mid-cycle silences the core side at once.
  always_comb begin
    state_d        = state_q;
    miss           = 1'b0;
    bus.rom_data_o = '0;
    bus.stallreq_o = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (bus.rom_ce_i) begin
            if (hit) begin
              bus.rom_data_o = line_q[req_idx];
            end else begin
              bus.stallreq_o = 1'b1;
              miss           = 1'b1;
              state_d        = FILL;
            end
          end
        end
        FILL: begin
          bus.stallreq_o = 1'b1;
          bus.mem_req_o  = 1'b1;
          bus.mem_addr_o = {tag_q, fill_idx_q, 2'b00};
          if (fill_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      tag_q        <= '0;
      fill_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (miss) begin
          tag_q        <= req_tag;
          valid_q      <= 1'b0;
          flush_pend_q <= 1'b0;
        end else if (bus.flush_i) begin
          valid_q <= 1'b0;
        end
      end else begin
        if (bus.flush_i) flush_pend_q <= 1'b1;
        if (bus.mem_ack_i) fill_idx_q <= fill_idx_q + 1'b1;
        // A flush seen anywhere in the fill, including its last edge, leaves the line invalid.
        if (fill_last) valid_q <= ~(flush_pend_q | bus.flush_i);
      end
    end
  end

  // Line storage needs no reset: valid_q guards every read.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && bus.mem_ack_i) line_q[fill_idx_q] <= bus.mem_rdata_i;
  end

`ifdef IFB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_linebuf.sv
// tb/tb_inst_fetch_linebuf.sv - vector table plus memory-address scoreboard for inst_fetch_linebuf
module tb_inst_fetch_linebuf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_linebuf_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IFB_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  inst_fetch_linebuf #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt));
`else
  inst_fetch_linebuf #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic [31:0] addr;
    int          waits;
    int          flush_beat;
    int          fills;
    int          exp_stalls;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          waits = 0;
  int          wait_cnt = 0;
  int          beat = 0;
  int          flush_beat = -1;
  logic        s_stall;
  logic        s_req;
  logic [31:0] s_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: sample at negedge, answer the memory request, return 1ns after posedge.
  task automatic tick();
    @(negedge clk);
    s_stall = bus.stallreq_o;
    s_req   = bus.mem_req_o;
    s_data  = bus.rom_data_o;
    bus.mem_ack_i = 1'b0;
    if (bus.mem_req_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", bus.mem_addr_o, 32'hFFFF_FFFF);
      end else if (wait_cnt >= waits) begin
        wait_cnt        = 0;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem_word(bus.mem_addr_o);
        check("req_addr", bus.mem_addr_o, exp_q.pop_front());
        if (beat == flush_beat) begin
          bus.flush_i = 1'b1;
          flush_beat  = -1;
        end
        beat++;
      end else begin
        check("req_addr_held", bus.mem_addr_o, exp_q[0]);
        wait_cnt++;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_ack_i = 1'b0;
    bus.flush_i   = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int w, input int fb, input int fills,
                          input int exp_st);
    int st;
    logic [31:0] base;
    st   = 0;
    base = {a[31:4], 4'h0};
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = a;
    waits      = w;
    flush_beat = fb;
    beat       = 0;
    wait_cnt   = 0;
    for (int f = 0; f < fills; f++)
      for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(i * 4));
    tick();
    while (s_stall && st < 200) begin
      st++;
      tick();
    end
    check("fetch_timeout", 32'(st >= 200), 32'd0);
    check("stall_cycles", 32'(st), 32'(exp_st));
    check("rom_data", s_data, mem_word(a));
    check("mem_req_after", {31'd0, s_req}, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h100, 0, -1, 1, 5};
    vecs[1] = '{32'h104, 0, -1, 0, 0};
    vecs[2] = '{32'h108, 0, -1, 0, 0};
    vecs[3] = '{32'h10C, 0, -1, 0, 0};
    vecs[4] = '{32'h110, 0, -1, 1, 5};
    vecs[5] = '{32'h100, 0, -1, 1, 5};
    vecs[6] = '{32'h200, 2, -1, 1, 13};
    vecs[7] = '{32'h20C, 2, -1, 0, 0};
    vecs[8] = '{32'h100, 0, 1, 2, 10};
    vecs[9] = '{32'h108, 0, -1, 0, 0};

    bus.rom_ce_i    = 1'b1;
    bus.rom_addr_i  = 32'h100;
    bus.flush_i     = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    @(negedge clk);
    check("rst_stall", {31'd0, bus.stallreq_o}, 32'd0);
    check("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'd0);
    check("rst_data", bus.rom_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      do_fetch(vecs[v].addr, vecs[v].waits, vecs[v].flush_beat, vecs[v].fills, vecs[v].exp_stalls);
`ifdef IFB_PERF_CNT_EN
      if (v == 3) begin
        check("miss_cnt", miss_cnt, 32'd1);
        check("hit_cnt", hit_cnt, 32'd4);
      end
`endif
    end

    // Fetch disabled: no data, no stall, no fill.
    bus.rom_ce_i   = 1'b0;
    bus.rom_addr_i = 32'h500;
    tick();
    check("ce0_stall", {31'd0, s_stall}, 32'd0);
    check("ce0_data", s_data, 32'd0);
    check("ce0_req", {31'd0, s_req}, 32'd0);

    // Stray ack while idle must not corrupt the line.
    bus.rom_ce_i    = 1'b1;
    bus.rom_addr_i  = 32'h108;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.mem_ack_i = 1'b0;
    do_fetch(32'h108, 0, -1, 0, 0);

    // Idle flush: same-cycle lookup still hits, next lookup misses.
    bus.flush_i = 1'b1;
    do_fetch(32'h104, 0, -1, 0, 0);
    do_fetch(32'h104, 0, -1, 1, 5);

    // Reset in the middle of a slow fill.
    bus.rom_addr_i = 32'h300;
    waits    = 2;
    wait_cnt = 0;
    beat     = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h300 + 32'(i * 4));
    for (int i = 0; i < 4; i++) tick();
    check("midfill_req", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("async_rst_stall", {31'd0, bus.stallreq_o}, 32'd0);
    check("async_rst_data", bus.rom_data_o, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    do_fetch(32'h300, 0, -1, 1, 5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
